// File: rtl/weight_loader_if.sv
// Handshake and bus bundle around the weight loader: host byte stream, weight buffer write port, sequencer start/ready.
// master = weight loader side, slave = host link / buffer / sequencer side.
interface weight_loader_if #(
  parameter int NUM_CHIPS_PER_CHAIN = 1
);
  localparam int CHIP_ADDR_WIDTH = (NUM_CHIPS_PER_CHAIN > 1) ? $clog2(NUM_CHIPS_PER_CHAIN) : 1;
  localparam int ADDR_WIDTH      = 12 + CHIP_ADDR_WIDTH;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_data;
  logic                  prog_start;
  logic                  prog_ready;

  modport master (
    input  in_data, in_valid, prog_ready,
    output in_ready, wr_en, wr_addr, wr_data, prog_start
  );

  modport slave (
    output in_data, in_valid, prog_ready,
    input  in_ready, wr_en, wr_addr, wr_data, prog_start
  );
endinterface

// File: rtl/weight_loader.sv
// Weight loader: unpacks a byte stream of 4-bit weight pairs into the weight buffer, then runs one programming pass.
// Define WEIGHT_LOADER_CHECKSUM_EN to require a trailing 8-bit modular checksum byte before programming starts.
module weight_loader #(
  parameter int NUM_CHIPS_PER_CHAIN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  weight_loader_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int CHIP_ADDR_WIDTH = (NUM_CHIPS_PER_CHAIN > 1) ? $clog2(NUM_CHIPS_PER_CHAIN) : 1;
  localparam int ADDR_WIDTH      = 12 + CHIP_ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CHIPS_PER_CHAIN * 4096 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WR_HI,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            byte_q;
  logic                  hs;
  logic                  last_pair;

  assign hs        = bus.in_valid & bus.in_ready;
  assign last_pair = (addr + ADDR_WIDTH'(1)) == LAST_ADDR;

  // NOTE: datapath registers carry no reset; every path that reads them writes them first.
  always_ff @(posedge clk) begin
    if (state == S_RECV && hs) byte_q <= bus.in_data;
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && load_start) sum <= '0;
    else if (state == S_RECV && hs)    sum <= sum + bus.in_data;
  end
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      bus.in_ready   <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.prog_start <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      err            <= 1'b0;
`endif
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      bus.wr_en      <= 1'b0;
      bus.prog_start <= 1'b0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            addr         <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            state        <= S_RECV;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            err          <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (hs) begin
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= addr;
            bus.wr_data  <= bus.in_data[3:0];
            bus.in_ready <= 1'b0;
            state        <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= addr + ADDR_WIDTH'(1);
          bus.wr_data <= byte_q[7:4];
          if (last_pair) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            bus.in_ready <= 1'b1;
            state        <= S_CHK;
`else
            state        <= S_START;
`endif
          end else begin
            addr         <= addr + ADDR_WIDTH'(2);
            bus.in_ready <= 1'b1;
            state        <= S_RECV;
          end
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (hs) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == sum) begin
              state <= S_START;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_START: begin
          bus.prog_start <= 1'b1;
          state          <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!bus.prog_ready) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.prog_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
Upstream stage of the programming sequencer.
- Accepts a byte stream of 4-bit weights over a valid/ready handshake.
- Writes the weights into the weight buffer RAM in the sequencer's address order {chip, row[5:0], col[5:0]}.
- When the full image is loaded, pulses the sequencer's start and waits for the programming pass to complete.
- Sits between the host byte link (UART/FIFO) and the weight buffer plus programming sequencer.

Parameters:
- NUM_CHIPS_PER_CHAIN, 1, number of chips in the chain; sets image size and chip address width.
- CHIP_ADDR_WIDTH (localparam), max(clog2(NUM_CHIPS_PER_CHAIN),1), chip field width.
- ADDR_WIDTH (localparam), 12+CHIP_ADDR_WIDTH, buffer address width.
- LAST_ADDR (localparam), NUM_CHIPS_PER_CHAIN*4096-1, final weight address.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a load; honoured only in S_IDLE.
- in_data  in  8  byte: [3:0] weight for even column, [7:4] weight for odd column.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_WIDTH  buffer address {chip, row, col}.
- wr_data  out  4  weight nibble.
- prog_start  out  1  one-cycle start to the programming sequencer.
- prog_ready  in  1  sequencer ready (high when idle, low while programming).
- busy  out  1  high in any state except S_IDLE.
- done  out  1  one-cycle pulse when programming completes.
- err  out  1  checksum error flag (macro-dependent).

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, prog_start=0, busy=0, done=0, err=0. State goes to S_IDLE and the address counter to 0.
- Reset mid-operation aborts immediately. No further writes or prog_start occur. Buffer contents are undefined and a new load_start is required.
- S_IDLE:
  - in_ready=0.
  - load_start=1: clear addr and err, go to S_RECV.
  - load_start in any other state is ignored.
- S_RECV:
  - in_ready=1.
  - On handshake: latch in_data. In the same edge, drive wr_en=1, wr_addr=addr, wr_data=in_data[3:0], then go to S_WR_HI.
  - in_valid low: hold with no write.
- S_WR_HI:
  - in_ready=0. Drive wr_en=1, wr_addr=addr+1, wr_data=latched[7:4].
  - addr+1==LAST_ADDR: go to S_START (or S_CHK with the macro).
  - Otherwise addr+=2 and go to S_RECV.
- Byte throughput is at most 1 per 2 cycles. wr_en is registered and high exactly one cycle per nibble.
- S_START: prog_start=1 for exactly one cycle, then go to S_WAIT_BUSY.
- S_WAIT_BUSY: wait for prog_ready==0. The sequencer drops ready on the cycle after start.
- S_WAIT_DONE:
  - Wait for prog_ready==1, then pulse done for one cycle and go to S_IDLE.
  - A prog_ready glitch low→high is accepted as completion. No timeout.
- Address counter width is ADDR_WIDTH. The column is always even in S_RECV. Chip boundary rollover is natural binary carry (0xFFF→0x1000).
- The chip field never exceeds NUM_CHIPS_PER_CHAIN-1 because the last-address check precedes the increment.
- A handshake is ignored outside S_RECV because in_ready=0 there.

Optional Feature:
- Macro: WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit modular sum of all image bytes is kept. It is cleared on load_start.
  - After the last image byte the FSM enters S_CHK with in_ready=1 and accepts one more byte.
  - Byte equals the sum: go to S_START.
  - Byte differs: err=1 (held until the next load_start or rst), no prog_start, go to S_IDLE. done is not pulsed.
- Not defined: no S_CHK state, err is tied to 0, and the sum logic is absent.

Test Plan:
- N=1, load_start, stream 2048 bytes with in_valid always high: exactly 4096 wr_en pulses.
  - Byte k=0xA5 writes 5 at 2k and A at 2k+1.
  - prog_start pulses once after the final write at 0xFFF.
  - Model prog_ready low for 100 cycles then high: done pulses once, busy falls.
- N=2: byte 2048 writes addr 0x1000 and 0x1001. Final write at 0x1FFF. No write at 0x2000.
- Randomly gapped in_valid: no write while in_valid=0. The address sequence is identical to the back-to-back case. in_ready is never high in S_WR_HI.
- load_start pulsed mid-load and during S_WAIT_DONE: ignored, addr unchanged. rst mid-load: all outputs return to 0 next cycle and in_ready stays 0 until load_start.
- With WEIGHT_LOADER_CHECKSUM_EN, N=1, all bytes 0x01:
  - Trailing 0x00 (sum of 2048 bytes mod 256 = 0): prog_start occurs.
  - Trailing 0x01: err=1, no prog_start, no done.
  - A subsequent load_start clears err.
